// File: rtl/operand_issue_stage.sv
// Decode-to-execute issue stage: scoreboarded RAW/WAW hazard hold, one-entry ID/EX register.
// Optional writeback bypass enabled by defining WB_BYPASS_EN.
module operand_issue_stage #(
  parameter int NREG   = 64,
  parameter int RIDX_W = 6,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [RIDX_W-1:0] in_rs,
  input  logic [RIDX_W-1:0] in_rt,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_ctrl_regwrt,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [RIDX_W-1:0] out_rf_rs,
  output logic [RIDX_W-1:0] out_rf_rt,
  input  logic [DATA_W-1:0] in_rf_rsval,
  input  logic [DATA_W-1:0] in_rf_rtval,
  input  logic              in_wb_valid,
  input  logic [RIDX_W-1:0] in_wb_rd,
  input  logic [DATA_W-1:0] in_wb_val,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [DATA_W-1:0] out_rsval,
  output logic [DATA_W-1:0] out_rtval,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_ctrl_regwrt,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              rs_byp, rt_byp, rd_byp;
  logic              hazard;
  logic              slot_free;
  logic              issue;
  logic [DATA_W-1:0] rs_op, rt_op;

  assign out_rf_rs = in_rs;
  assign out_rf_rt = in_rt;

`ifdef WB_BYPASS_EN
  assign rs_byp = in_wb_valid && (in_wb_rd == in_rs);
  assign rt_byp = in_wb_valid && (in_wb_rd == in_rt);
  assign rd_byp = in_wb_valid && (in_wb_rd == in_rd);
  assign rs_op  = rs_byp ? in_wb_val : in_rf_rsval;
  assign rt_op  = rt_byp ? in_wb_val : in_rf_rtval;
`else
  logic unused_wb_val;
  assign unused_wb_val = ^in_wb_val;
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
  assign rd_byp = 1'b0;
  assign rs_op  = in_rf_rsval;
  assign rt_op  = in_rf_rtval;
`endif

  // Hazards look only at registered busy; a same-cycle retire helps only through bypass.
  assign hazard = (busy[in_rs] & ~rs_byp)
                | (busy[in_rt] & ~rt_byp)
                | (in_ctrl_regwrt & busy[in_rd] & ~rd_byp);

  assign slot_free = ~out_valid | in_ready;
  assign out_ready = slot_free & ~hazard & ~in_flush;
  assign issue     = in_valid & out_ready;

  // Later assignments win: wb clear, then flush clear, then issue set.
  always_comb begin
    busy_nxt = busy;
    if (in_wb_valid)
      busy_nxt[in_wb_rd] = 1'b0;
    if (in_flush && out_valid && out_ctrl_regwrt)
      busy_nxt[out_rd] = 1'b0;
    if (issue && in_ctrl_regwrt)
      busy_nxt[in_rd] = 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_valid       <= 1'b0;
      out_rsval       <= '0;
      out_rtval       <= '0;
      out_rd          <= '0;
      out_ctrl_regwrt <= 1'b0;
      out_ctrl        <= '0;
    end else if (in_flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid       <= 1'b1;
      out_rsval       <= rs_op;
      out_rtval       <= rt_op;
      out_rd          <= in_rd;
      out_ctrl_regwrt <= in_ctrl_regwrt;
      out_ctrl        <= in_ctrl;
    end else if (in_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage; follows WB_BYPASS_EN if defined at compile time.
module tb_operand_issue_stage;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [5:0]  in_rs, in_rt, in_rd;
  logic        in_ctrl_regwrt;
  logic [7:0]  in_ctrl;
  logic [5:0]  out_rf_rs, out_rf_rt;
  logic [31:0] in_rf_rsval, in_rf_rtval;
  logic        in_wb_valid;
  logic [5:0]  in_wb_rd;
  logic [31:0] in_wb_val;
  logic        in_flush;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_rsval, out_rtval;
  logic [5:0]  out_rd;
  logic        out_ctrl_regwrt;
  logic [7:0]  out_ctrl;

  int total = 0;
  int bad   = 0;

  operand_issue_stage #(.NREG(64), .RIDX_W(6), .DATA_W(32), .CTRL_W(8)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl_regwrt(in_ctrl_regwrt),
    .in_ctrl(in_ctrl), .out_rf_rs(out_rf_rs), .out_rf_rt(out_rf_rt),
    .in_rf_rsval(in_rf_rsval), .in_rf_rtval(in_rf_rtval), .in_wb_valid(in_wb_valid),
    .in_wb_rd(in_wb_rd), .in_wb_val(in_wb_val), .in_flush(in_flush), .out_valid(out_valid),
    .in_ready(in_ready), .out_rsval(out_rsval), .out_rtval(out_rtval), .out_rd(out_rd),
    .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl(out_ctrl)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                           input logic [5:0] rd, input logic wr, input logic [7:0] ctrl);
    in_valid       = v;
    in_rs          = rs;
    in_rt          = rt;
    in_rd          = rd;
    in_ctrl_regwrt = wr;
    in_ctrl        = ctrl;
  endtask

  initial begin
    in_rst_n = 1'b0;
    set_instr(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 8'h00);
    in_rf_rsval = '0; in_rf_rtval = '0;
    in_wb_valid = 1'b0; in_wb_rd = '0; in_wb_val = '0;
    in_flush = 1'b0; in_ready = 1'b1;

    // reset state
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_rsval", out_rsval, 0);
    check("rst_rd", out_rd, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_ready", out_ready, 1);
    #10 in_rst_n = 1'b1;

    // independent stream, back to back
    @(posedge in_clk); #1;
    set_instr(1'b1, 6'd1, 6'd2, 6'd3, 1'b0, 8'hA5);
    in_rf_rsval = 32'd12; in_rf_rtval = 32'h20;
    #1;
    check("rf_rs_idx", out_rf_rs, 1);
    check("rf_rt_idx", out_rf_rt, 2);
    check("ind_ready0", out_ready, 1);
    tick();
    check("ind_valid0", out_valid, 1);
    check("ind_rsval0", out_rsval, 12);
    check("ind_rtval0", out_rtval, 32'h20);
    check("ind_rd0", out_rd, 3);
    check("ind_ctrl0", out_ctrl, 8'hA5);
    set_instr(1'b1, 6'd4, 6'd5, 6'd6, 1'b0, 8'h5A);
    in_rf_rsval = 32'h44; in_rf_rtval = 32'h55;
    #1 check("ind_ready1", out_ready, 1);
    tick();
    check("ind_rsval1", out_rsval, 32'h44);
    check("ind_rtval1", out_rtval, 32'h55);
    check("ind_rd1", out_rd, 6);
    in_valid = 1'b0;
    tick();
    check("ind_drain", out_valid, 0);

    // RAW on r3
    set_instr(1'b1, 6'd1, 6'd2, 6'd3, 1'b1, 8'h11);
    in_rf_rsval = 32'h12; in_rf_rtval = 32'h13;
    tick();
    check("raw_prod_valid", out_valid, 1);
    check("raw_prod_wrt", out_ctrl_regwrt, 1);
    set_instr(1'b1, 6'd3, 6'd4, 6'd5, 1'b1, 8'h22);
    in_rf_rsval = 32'h11; in_rf_rtval = 32'h44;
    #1 check("raw_stall", out_ready, 0);
    tick();
    check("raw_bubble", out_valid, 0);
    check("raw_stall2", out_ready, 0);
    in_wb_valid = 1'b1; in_wb_rd = 6'd3; in_wb_val = 32'h2C;
    #1;
`ifdef WB_BYPASS_EN
    check("raw_byp_ready", out_ready, 1);
    tick();
    in_wb_valid = 1'b0;
    check("raw_byp_valid", out_valid, 1);
    check("raw_byp_rsval", out_rsval, 32'h2C);
    check("raw_byp_rtval", out_rtval, 32'h44);
`else
    check("raw_retire_ready", out_ready, 0);
    tick();
    in_wb_valid = 1'b0;
    check("raw_retire_valid", out_valid, 0);
    #1 check("raw_after_ready", out_ready, 1);
    tick();
    check("raw_after_valid", out_valid, 1);
    check("raw_after_rsval", out_rsval, 32'h11);
`endif
    check("raw_dep_rd", out_rd, 5);
    in_valid = 1'b0;
    in_wb_valid = 1'b1; in_wb_rd = 6'd5;
    tick();
    in_wb_valid = 1'b0;
    tick();
    check("raw_drain", out_valid, 0);

    // backpressure
    set_instr(1'b1, 6'd1, 6'd2, 6'd8, 1'b0, 8'h3C);
    in_rf_rsval = 32'h100; in_rf_rtval = 32'h200;
    tick();
    in_ready = 1'b0;
    set_instr(1'b1, 6'd10, 6'd11, 6'd12, 1'b0, 8'h77);
    in_rf_rsval = 32'h300; in_rf_rtval = 32'h400;
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check("bp_ready", out_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_rsval", out_rsval, 32'h100);
      check("bp_ctrl", out_ctrl, 8'h3C);
    end
    in_ready = 1'b1;
    #1 check("bp_release_ready", out_ready, 1);
    tick();
    check("bp_repl_valid", out_valid, 1);
    check("bp_repl_rsval", out_rsval, 32'h300);
    check("bp_repl_rd", out_rd, 12);
    check("bp_repl_ctrl", out_ctrl, 8'h77);
    in_valid = 1'b0;
    tick();
    check("bp_drain", out_valid, 0);

    // flush of held producer of r7
    set_instr(1'b1, 6'd1, 6'd2, 6'd7, 1'b1, 8'h55);
    tick();
    check("fl_held", out_valid, 1);
    in_ready = 1'b0;
    set_instr(1'b1, 6'd7, 6'd1, 6'd0, 1'b0, 8'h66);
    in_rf_rsval = 32'h777; in_rf_rtval = 32'h1;
    in_flush = 1'b1;
    #1 check("fl_ready", out_ready, 0);
    tick();
    check("fl_killed", out_valid, 0);
    in_flush = 1'b0;
    #1 check("fl_busy_clear", out_ready, 1);
    tick();
    check("fl_next_valid", out_valid, 1);
    check("fl_next_rsval", out_rsval, 32'h777);
    check("fl_next_ctrl", out_ctrl, 8'h66);
    in_ready = 1'b1;
    in_valid = 1'b0;
    tick();

    // retire r9 on the same edge an issue sets r9
    set_instr(1'b1, 6'd1, 6'd2, 6'd9, 1'b1, 8'h99);
    in_wb_valid = 1'b1; in_wb_rd = 6'd9;
    #1 check("col_ready", out_ready, 1);
    tick();
    in_wb_valid = 1'b0;
    check("col_valid", out_valid, 1);
    set_instr(1'b1, 6'd9, 6'd1, 6'd10, 1'b0, 8'h00);
    #1 check("col_busy", out_ready, 0);
    set_instr(1'b1, 6'd1, 6'd2, 6'd9, 1'b1, 8'h00);
    #1 check("waw_stall", out_ready, 0);
    set_instr(1'b1, 6'd1, 6'd2, 6'd9, 1'b0, 8'h00);
    #1 check("waw_nowrt", out_ready, 1);
    in_valid = 1'b0;
    tick();
    in_wb_valid = 1'b1; in_wb_rd = 6'd9;
    tick();
    in_wb_valid = 1'b0;
    set_instr(1'b1, 6'd9, 6'd1, 6'd10, 1'b0, 8'h00);
    #1 check("col_retired", out_ready, 1);
    tick();
    check("col_dep_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();

    // reset mid-operation with busy r20 and a held instruction
    set_instr(1'b1, 6'd1, 6'd2, 6'd20, 1'b1, 8'hAB);
    in_rf_rsval = 32'h5; in_rf_rtval = 32'h6;
    in_ready = 1'b0;
    tick();
    check("mrst_pre_valid", out_valid, 1);
    in_valid = 1'b0;
    in_rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_rsval", out_rsval, 0);
    check("mrst_ctrl", out_ctrl, 0);
    check("mrst_wrt", out_ctrl_regwrt, 0);
    #2 in_rst_n = 1'b1;
    set_instr(1'b1, 6'd20, 6'd20, 6'd20, 1'b1, 8'h00);
    #1 check("mrst_busy_clear", out_ready, 1);
    tick();
    check("mrst_issue", out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
